// File: rtl/cmm_job_sequencer.sv
// Job sequencer for a complex matrix-multiply engine: walks dot-product indices row-major,
// throttles issues by in-flight count, and registers ordered results. Optional macro: CMM_SEQ_DIM_CHECK_EN.
module cmm_job_sequencer #(
  parameter int MAX_OUT = 4,
  parameter int DIM_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [DIM_W-1:0] cmd_rows_i,
  input  logic [DIM_W-1:0] cmd_cols_i,
  input  logic             flush_i,
  output logic             eng_in_valid_o,
  input  logic             eng_in_ready_i,
  output logic [DIM_W-1:0] eng_row_o,
  output logic [DIM_W-1:0] eng_col_o,
  input  logic             eng_out_valid_i,
  output logic             eng_out_ready_o,
  input  logic [127:0]     eng_result_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [127:0]     res_data_o,
  output logic [DIM_W-1:0] res_row_o,
  output logic [DIM_W-1:0] res_col_o,
  output logic             res_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       state_o,
  output logic [3:0]       outstanding_o
);

  // Handshakes (cmd, eng_in, eng_out, res): a transfer occurs on a rising edge where valid and
  // ready are both high; a source keeps valid and its payload stable until that transfer.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

  state_t state, state_d;

  logic [DIM_W-1:0] rows_q, cols_q, rows_m1, cols_m1;
  logic [DIM_W-1:0] iss_row, iss_col, rcv_row, rcv_col;
  logic [3:0]       outstanding;
  logic             res_valid_q, res_last_q;
  logic [127:0]     res_data_q;
  logic [DIM_W-1:0] res_row_q, res_col_q;
  logic             done_q, done_d;
  logic             cmd_hs, cmd_zero, dims_zero;
  logic             issue_hs, issue_last, rcv_last;
  logic             eng_hs, accept, res_hs;

`ifdef CMM_SEQ_DIM_CHECK_EN
  logic err_q, err_d;
`endif

  assign rows_m1    = rows_q - DIM_W'(1);
  assign cols_m1    = cols_q - DIM_W'(1);
  assign dims_zero  = (rows_q == '0) || (cols_q == '0);

  assign cmd_ready_o = (state == IDLE);
  assign cmd_hs      = cmd_valid_i && cmd_ready_o && !flush_i;
  assign cmd_zero    = (cmd_rows_i == '0) || (cmd_cols_i == '0);

  assign eng_in_valid_o = (state == ISSUE) && (outstanding < MAX_OUT_L);
  assign issue_hs       = eng_in_valid_o && eng_in_ready_i;
  assign issue_last     = (iss_row == rows_m1) && (iss_col == cols_m1);
  assign rcv_last       = (rcv_row == rows_m1) && (rcv_col == cols_m1);

  // IDLE always sinks engine results so stragglers from an aborted job drain away.
  assign eng_out_ready_o = (state == IDLE) || !res_valid_q || res_ready_i;
  assign eng_hs          = eng_out_valid_i && eng_out_ready_o;
  assign accept          = eng_hs && (state != IDLE) && !flush_i;
  assign res_hs          = res_valid_q && res_ready_i;

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
`ifdef CMM_SEQ_DIM_CHECK_EN
    err_d   = 1'b0;
`endif
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_hs) begin
            if (cmd_zero) begin
`ifdef CMM_SEQ_DIM_CHECK_EN
              err_d = 1'b1;
`else
              state_d = DRAIN;
`endif
            end else begin
              state_d = ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue_hs && issue_last) state_d = DRAIN;
        end
        DRAIN: begin
          if (dims_zero || (res_hs && res_last_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= done_d;
    end
  end

`ifdef CMM_SEQ_DIM_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Issue and result counters both saturate on the final coordinate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rows_q      <= '0;
      cols_q      <= '0;
      iss_row     <= '0;
      iss_col     <= '0;
      rcv_row     <= '0;
      rcv_col     <= '0;
      outstanding <= '0;
    end else if (flush_i) begin
      iss_row     <= '0;
      iss_col     <= '0;
      rcv_row     <= '0;
      rcv_col     <= '0;
      outstanding <= '0;
    end else if (cmd_hs) begin
      rows_q      <= cmd_rows_i;
      cols_q      <= cmd_cols_i;
      iss_row     <= '0;
      iss_col     <= '0;
      rcv_row     <= '0;
      rcv_col     <= '0;
      outstanding <= '0;
    end else begin
      if (issue_hs && !issue_last) begin
        if (iss_col == cols_m1) begin
          iss_col <= '0;
          iss_row <= iss_row + DIM_W'(1);
        end else begin
          iss_col <= iss_col + DIM_W'(1);
        end
      end
      if (accept && !rcv_last) begin
        if (rcv_col == cols_m1) begin
          rcv_col <= '0;
          rcv_row <= rcv_row + DIM_W'(1);
        end else begin
          rcv_col <= rcv_col + DIM_W'(1);
        end
      end
      unique case ({issue_hs, accept})
        2'b10: if (outstanding < MAX_OUT_L) outstanding <= outstanding + 4'd1;
        2'b01: if (outstanding != 4'd0)     outstanding <= outstanding - 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      res_row_q   <= '0;
      res_col_q   <= '0;
    end else if (flush_i) begin
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      res_last_q  <= rcv_last;
      res_data_q  <= eng_result_i;
      res_row_q   <= rcv_row;
      res_col_q   <= rcv_col;
    end else if (res_hs) begin
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
    end
  end

  assign eng_row_o     = iss_row;
  assign eng_col_o     = iss_col;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign res_row_o     = res_row_q;
  assign res_col_o     = res_col_q;
  assign res_last_o    = res_last_q;
  assign busy_o        = (state != IDLE);
  assign done_o        = done_q;
  assign state_o       = state;
  assign outstanding_o = outstanding;

endmodule

// File: tb/tb_cmm_job_sequencer.sv
// Directed bench for cmm_job_sequencer: a table of whole jobs plus hand-written sequences
// for throttling, back-pressure, flush, reset mid-job and zero-dimension commands.
module tb_cmm_job_sequencer;
  localparam int DIM_W = 8;
  localparam int RW    = 128 + 2*DIM_W + 1;

  logic             clk_i;
  logic             rst_ni;
  logic             cmd_valid_i, cmd_ready_o;
  logic [DIM_W-1:0] cmd_rows_i, cmd_cols_i;
  logic             flush_i;
  logic             eng_in_valid_o, eng_in_ready_i;
  logic [DIM_W-1:0] eng_row_o, eng_col_o;
  logic             eng_out_valid_i, eng_out_ready_o;
  logic [127:0]     eng_result_i;
  logic             res_valid_o, res_ready_i;
  logic [127:0]     res_data_o;
  logic [DIM_W-1:0] res_row_o, res_col_o;
  logic             res_last_o, busy_o, done_o, err_o;
  logic [1:0]       state_o;
  logic [3:0]       outstanding_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  cmm_job_sequencer #(.MAX_OUT(4), .DIM_W(DIM_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_rows_i(cmd_rows_i), .cmd_cols_i(cmd_cols_i), .flush_i(flush_i),
    .eng_in_valid_o(eng_in_valid_o), .eng_in_ready_i(eng_in_ready_i),
    .eng_row_o(eng_row_o), .eng_col_o(eng_col_o),
    .eng_out_valid_i(eng_out_valid_i), .eng_out_ready_o(eng_out_ready_o),
    .eng_result_i(eng_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_row_o(res_row_o), .res_col_o(res_col_o), .res_last_o(res_last_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .state_o(state_o), .outstanding_o(outstanding_o)
  );

  typedef struct { int rows; int cols; int lat; int eng_rand; int res_rand; int exp_n; } job_t;
  typedef struct { logic [127:0] data; int due; } pend_t;

  job_t             jobs[5];
  pend_t            pend[$];
  logic [RW-1:0]    exp_q[$];
  logic [2*DIM_W-1:0] iss_q[$];

  int n_cmp, n_fail;
  int cyc, lat, res_hold;
  bit eng_en, eng_rdy, eng_rand, res_rand, cmd_pend, flush_req;
  logic [DIM_W-1:0] cmd_rows, cmd_cols;
  int n_issue, n_res, n_done, n_err, n_unstable;
  int accept_step, last_res_step, done_step, err_step;
  bit saw_in_hs, saw_out_hs, saw_cmd, held;
  logic [2*DIM_W-1:0] held_coord;

  function automatic logic [127:0] mk_data(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
    return {48'hC0FFEE_123456, r, c, 48'h0BAD_F00D_CAFE, c, r};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prepare(input int rows, input int cols);
    exp_q.delete();
    iss_q.delete();
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        iss_q.push_back({DIM_W'(r), DIM_W'(c)});
        exp_q.push_back({mk_data(DIM_W'(r), DIM_W'(c)), DIM_W'(r), DIM_W'(c),
                         (r == rows - 1) && (c == cols - 1)});
      end
  endtask

  task automatic clear_counts();
    n_issue = 0; n_res = 0; n_done = 0; n_err = 0; n_unstable = 0;
    accept_step = 0; last_res_step = 0; done_step = 0; err_step = 0;
    held = 1'b0;
  endtask

  // One clock: drive at the falling edge, observe #1 later what the next rising edge will take.
  task automatic step();
    @(negedge clk_i);
    cmd_valid_i = cmd_pend;
    cmd_rows_i  = cmd_rows;
    cmd_cols_i  = cmd_cols;
    flush_i     = flush_req;
    if (res_hold > 0) begin
      res_ready_i = 1'b0;
      res_hold--;
    end else if (res_rand) res_ready_i = ($urandom_range(0, 3) != 0);
    else res_ready_i = 1'b1;
    eng_in_ready_i = eng_rand ? ($urandom_range(0, 2) != 0) : eng_rdy;
    if (eng_en && pend.size() > 0 && pend[0].due <= cyc) begin
      eng_out_valid_i = 1'b1;
      eng_result_i    = pend[0].data;
    end else begin
      eng_out_valid_i = 1'b0;
      eng_result_i    = '0;
    end
    #1;
    if (held && eng_in_valid_o && ({eng_row_o, eng_col_o} != held_coord)) n_unstable++;
    held       = eng_in_valid_o && !eng_in_ready_i;
    held_coord = {eng_row_o, eng_col_o};
    saw_cmd    = cmd_valid_i && cmd_ready_o && !flush_i;
    if (saw_cmd) begin
      cmd_pend    = 1'b0;
      accept_step = cyc;
    end
    flush_req  = 1'b0;
    saw_in_hs  = eng_in_valid_o && eng_in_ready_i;
    saw_out_hs = eng_out_valid_i && eng_out_ready_o;
    if (saw_out_hs) pend.delete(0);
    if (saw_in_hs) begin
      n_issue++;
      check("issue_expected", iss_q.size() > 0, 1);
      if (iss_q.size() > 0) check("issue_coord", {eng_row_o, eng_col_o}, iss_q.pop_front());
      pend.push_back('{data: mk_data(eng_row_o, eng_col_o), due: cyc + lat});
    end
    if (res_valid_o && res_ready_i) begin
      n_res++;
      last_res_step = cyc;
      check("res_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0)
        check("res_data_coord_last", {res_data_o, res_row_o, res_col_o, res_last_o}, exp_q.pop_front());
    end
    if (done_o) begin n_done++; done_step = cyc; end
    if (err_o)  begin n_err++;  err_step  = cyc; end
    cyc++;
  endtask

  task automatic send_cmd(input int rows, input int cols);
    prepare(rows, cols);
    cmd_rows = DIM_W'(rows);
    cmd_cols = DIM_W'(cols);
    cmd_pend = 1'b1;
    for (int i = 0; i < 20 && cmd_pend; i++) step();
    check("cmd_accepted", cmd_pend, 0);
    cmd_pend = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, ni, bad;
    logic [127:0] held_data;
    n_cmp = 0; n_fail = 0; cyc = 0; lat = 1; res_hold = 0;
    eng_en = 1'b1; eng_rdy = 1'b1; eng_rand = 1'b0; res_rand = 1'b0;
    cmd_pend = 1'b0; flush_req = 1'b0; cmd_rows = '0; cmd_cols = '0;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_rows_i = '0; cmd_cols_i = '0; flush_i = 1'b0;
    eng_in_ready_i = 1'b0; eng_out_valid_i = 1'b0; eng_result_i = '0; res_ready_i = 1'b0;
    clear_counts();

    jobs[0] = '{2, 3, 3, 0, 0, 6};
    jobs[1] = '{1, 1, 1, 0, 0, 1};
    jobs[2] = '{3, 2, 6, 1, 1, 6};
    jobs[3] = '{1, 4, 2, 0, 1, 4};
    jobs[4] = '{4, 3, 1, 1, 0, 12};

    // Reset values while reset is held.
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_eng_in_valid", eng_in_valid_o, 0);
    check("rst_res_valid_last", {res_valid_o, res_last_o}, 0);
    check("rst_busy_done_err", {busy_o, done_o, err_o}, 0);
    check("rst_eng_out_ready", eng_out_ready_o, 1);
    check("rst_res_data", res_data_o, 0);
    check("rst_indices", {eng_row_o, eng_col_o, res_row_o, res_col_o}, 0);
    check("rst_state", state_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Whole jobs from the table.
    for (int j = 0; j < 5; j++) begin
      lat = jobs[j].lat;
      eng_rand = (jobs[j].eng_rand != 0);
      res_rand = (jobs[j].res_rand != 0);
      eng_en = 1'b1; eng_rdy = 1'b1;
      clear_counts();
      send_cmd(jobs[j].rows, jobs[j].cols);
      run_until_done(600);
      repeat (4) step();
      check($sformatf("job%0d_issues", j), n_issue, jobs[j].exp_n);
      check($sformatf("job%0d_results", j), n_res, jobs[j].exp_n);
      check($sformatf("job%0d_done_count", j), n_done, 1);
      check($sformatf("job%0d_done_after_last", j), done_step - last_res_step, 1);
      check($sformatf("job%0d_exp_left", j), exp_q.size(), 0);
      check($sformatf("job%0d_idx_stable", j), n_unstable, 0);
      check($sformatf("job%0d_idle", j), busy_o, 0);
      check($sformatf("job%0d_engine_empty", j), pend.size(), 0);
    end
    eng_rand = 1'b0; res_rand = 1'b0;

    // Throttle at MAX_OUT, then simultaneous issue/result at outstanding=2, then flush.
    clear_counts(); lat = 0; eng_en = 1'b0; eng_rdy = 1'b1;
    send_cmd(3, 3);
    repeat (12) step();
    check("thr_issues", n_issue, 4);
    check("thr_in_valid", eng_in_valid_o, 0);
    check("thr_outstanding", outstanding_o, 4);
    check("thr_state", state_o, 1);
    eng_rdy = 1'b0; eng_en = 1'b1;
    step(); step();
    @(posedge clk_i); #1;
    check("thr_outstanding_two", outstanding_o, 2);
    eng_rdy = 1'b1;
    step();
    check("simul_both_hs", {saw_in_hs, saw_out_hs}, 2'b11);
    @(posedge clk_i); #1;
    check("simul_outstanding", outstanding_o, 2);
    eng_en = 1'b0; eng_rdy = 1'b0; flush_req = 1'b1;
    step();
    @(posedge clk_i); #1;
    check("thr_flush_idle", {busy_o, res_valid_o}, 0);
    check("thr_flush_outstanding", outstanding_o, 0);
    exp_q.delete(); iss_q.delete();
    nr = n_res;
    eng_en = 1'b1; eng_rdy = 1'b1;
    repeat (10) step();
    check("thr_stragglers_gone", pend.size(), 0);
    check("thr_no_res", n_res, nr);
    check("thr_no_done", n_done, 0);
    check("thr_no_issue", n_issue, 5);

    // Flush after 3 issues; the 3 late results must be discarded.
    clear_counts(); lat = 1; eng_en = 1'b0; eng_rdy = 1'b1;
    send_cmd(2, 3);
    for (int i = 0; i < 20 && n_issue < 3; i++) step();
    eng_rdy = 1'b0; flush_req = 1'b1;
    step();
    @(posedge clk_i); #1;
    check("fl_state_idle", {state_o, busy_o}, 0);
    exp_q.delete(); iss_q.delete();
    eng_en = 1'b1;
    repeat (12) step();
    check("fl_issues", n_issue, 3);
    check("fl_no_res", n_res, 0);
    check("fl_no_done", n_done, 0);
    check("fl_late_consumed", pend.size(), 0);

    // Flush wins over a simultaneous command in IDLE.
    clear_counts(); eng_rdy = 1'b1;
    cmd_rows = 8'd1; cmd_cols = 8'd1; cmd_pend = 1'b1; flush_req = 1'b1;
    step();
    cmd_pend = 1'b0;
    @(posedge clk_i); #1;
    check("flcmd_not_busy", busy_o, 0);
    repeat (5) step();
    check("flcmd_no_issue", n_issue, 0);

    // Result register back-pressure for 10 cycles.
    clear_counts(); lat = 1; eng_en = 1'b1; eng_rdy = 1'b1; res_hold = 1000;
    send_cmd(2, 2);
    repeat (8) step();
    check("bp_valid", res_valid_o, 1);
    check("bp_first_data", res_data_o, mk_data(8'd0, 8'd0));
    check("bp_out_ready", eng_out_ready_o, 0);
    held_data = res_data_o;
    bad = 0;
    repeat (10) begin
      step();
      if (res_data_o !== held_data || eng_out_ready_o !== 1'b0 || res_valid_o !== 1'b1) bad++;
    end
    check("bp_stable", bad, 0);
    res_hold = 0;
    run_until_done(200);
    repeat (3) step();
    check("bp_results", n_res, 4);
    check("bp_done", n_done, 1);
    check("bp_exp_left", exp_q.size(), 0);
    check("bp_engine_empty", pend.size(), 0);

    // Zero-dimension command.
    clear_counts();
    send_cmd(0, 5);
    repeat (6) step();
`ifdef CMM_SEQ_DIM_CHECK_EN
    check("zero_err_count", n_err, 1);
    check("zero_err_timing", err_step - accept_step, 1);
    check("zero_no_done", n_done, 0);
`else
    check("zero_done_count", n_done, 1);
    check("zero_done_timing", done_step - accept_step, 2);
    check("zero_no_err", n_err, 0);
`endif
    check("zero_no_issue", n_issue, 0);
    check("zero_no_res", n_res, 0);

    // Reset asserted mid-job abandons it.
    clear_counts(); lat = 2; eng_en = 1'b1; eng_rdy = 1'b1;
    send_cmd(2, 2);
    repeat (3) step();
    ni = n_issue;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mrst_outputs", {busy_o, eng_in_valid_o, res_valid_o, done_o}, 0);
    check("mrst_out_ready", eng_out_ready_o, 1);
    check("mrst_outstanding", outstanding_o, 0);
    repeat (2) step();
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_q.delete(); iss_q.delete();
    repeat (15) step();
    check("mrst_no_done", n_done, 0);
    check("mrst_no_res", n_res, 0);
    check("mrst_no_new_issue", n_issue, ni);
    check("mrst_engine_empty", pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmm_job_sequencer.md
CMM_JOB_SEQUENCER -- requirements
Module: cmm_job_sequencer

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4: max engine operations in flight (1..15).
REQ-002 SHALL have parameter DIM_W, default 8: width of row/column dimensions and indices.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1/1  job command handshake.
REQ-006 cmd_rows_i, cmd_cols_i  in  DIM_W each  result-matrix rows and columns for the job.
REQ-007 flush_i  in  1  abort the current job.
REQ-008 eng_in_valid_o / eng_in_ready_i  out/in  1/1  dot-product issue handshake to the complex matrix-mul engine.
REQ-009 eng_row_o, eng_col_o  out  DIM_W each  operand row/column index of the issued dot product.
REQ-010 eng_out_valid_i / eng_out_ready_o  in/out  1/1  engine result handshake; the engine returns results in order.
REQ-011 eng_result_i  in  128  engine result {imag[127:64], real[63:0]}.
REQ-012 res_valid_o / res_ready_i  out/in  1/1  result stream handshake.
REQ-013 res_data_o  out  128  registered copy of eng_result_i.
REQ-014 res_row_o, res_col_o  out  DIM_W each  result coordinates; res_last_o  out  1  final element of the job.
REQ-015 busy_o  out  1  high in any state other than IDLE.
REQ-016 done_o  out  1  one-cycle job-complete pulse.
REQ-017 err_o  out  1  one-cycle bad-command pulse (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, ISSUE and DRAIN; cmd_ready_o=1 only in IDLE.
REQ-019 IDLE, on cmd handshake: latch dims, clear issue, result and outstanding counters, go to ISSUE; eng_in_valid_o rises the next cycle.
REQ-020 ISSUE: eng_in_valid_o=1 iff outstanding<MAX_OUT; indices SHALL walk row-major, column inner, from (0,0) to (rows-1,cols-1).
REQ-021 eng_row_o/eng_col_o SHALL stay stable while eng_in_valid_o=1 and eng_in_ready_i=0.
REQ-022 ISSUE -> DRAIN SHALL occur on the issue handshake of (rows-1,cols-1).
REQ-023 outstanding SHALL be +1 on an issue handshake, -1 on an engine-result handshake, and unchanged when both occur in the same cycle; it SHALL never exceed MAX_OUT or go below 0.
REQ-024 Output register: eng_out_ready_o = !res_valid_o || res_ready_i; an engine-result handshake at cycle t SHALL present res_valid_o at t+1 with data and coordinates (1-cycle latency); res_valid_o holds until res_ready_i.
REQ-025 Result coordinates SHALL come from a separate row-major result counter; res_last_o=1 only with coordinate (rows-1,cols-1).
REQ-026 On the res handshake with res_last_o=1: go to IDLE; done_o pulses the following cycle.
REQ-027 Results SHALL be accepted in ISSUE and DRAIN; IDLE SHALL assert eng_out_ready_o=1 and discard results, covering stragglers after a flush.
REQ-028 flush_i in any state: next cycle IDLE, res_valid_o=0, counters cleared, no done_o; flush_i has priority over a simultaneous cmd handshake, which is not accepted.
REQ-029 Counter wrap is forbidden; the index counters SHALL saturate at the latched dims.

Reset
REQ-030 While rst_ni=0: state IDLE; cmd_ready_o=1; eng_in_valid_o, res_valid_o, res_last_o, busy_o, done_o and err_o =0; eng_out_ready_o=1; data and index outputs =0.
REQ-031 Reset asserted mid-job SHALL abandon the job immediately, with no done_o after release.

Configuration
REQ-032 Macro CMM_SEQ_DIM_CHECK_EN defined: a command with rows=0 or cols=0 SHALL be accepted, stay in IDLE, and pulse err_o the next cycle with no engine issue.
REQ-033 CMM_SEQ_DIM_CHECK_EN undefined: err_o tied 0; a zero-dimension command SHALL enter DRAIN directly and pulse done_o 2 cycles after acceptance with no issue or result.

Verification
REQ-034 cmd 2x3, engine ready always, 3-cycle latency, res_ready=1 -> 6 issues (0,0)..(1,2), 6 results in order, res_last_o on (1,2), one done_o pulse.
REQ-035 MAX_OUT=4, engine never returns results -> exactly 4 issues, then eng_in_valid_o=0 indefinitely with outstanding=4.
REQ-036 res_ready_i=0 for 10 cycles mid-job -> eng_out_ready_o=0 while the register is full, no data loss, res_data_o stable.
REQ-037 Issue and result handshakes in the same cycle at outstanding=2 -> outstanding stays 2.
REQ-038 flush_i in ISSUE after 3 issues -> IDLE next cycle, 3 late engine results discarded, no res_valid_o, no done_o.
REQ-039 cmd 0x5 -> with CMM_SEQ_DIM_CHECK_EN, err_o pulse and no issue; without it, done_o 2 cycles later and no issue.
